gshare_spec_predictor: RTL and testbench
========================================

// Module: gshare_spec_predictor
// PURPOSE
//  Global-history branch direction predictor: table of N-bit saturating counters indexed by PC bits
//  hashed with an internal speculative global history register (GHR). Separate predict/update ports.
//  Sits between fetch (predict) and branch resolution (update); restores GHR on mispredict.
// PARAMETERS
//  K         4  PC index bits.
//  M         4  GHR length in bits.
//  N         2  counter width (N>=2).
//  HASH_XOR  0  0: idx={ghr,pc} (IW=K+M); 1: idx=pc^{{K-M}'0,ghr} (IW=K, requires M<=K).
// PORTS
//  clk           in   1   clock.
//  reset         in   1   asynchronous, active-high reset.
//  pred_valid    in   1   fetch requests a prediction this cycle.
//  pred_pc       in   K   PC index bits of the fetched branch.
//  pred_taken    out  1   predicted direction (combinational, counter MSB).
//  pred_ghr      out  M   GHR snapshot used for this prediction; fetch carries it to resolve.
//  upd_valid     in   1   branch resolved this cycle.
//  upd_pc        in   K   PC index bits of the resolved branch.
//  upd_ghr       in   M   snapshot returned from pred_ghr at prediction time.
//  upd_taken     in   1   actual outcome.
//  upd_mispred   in   1   resolved direction differed from prediction.
//  stat_preds    out  32  predictions issued (GSHARE_STATS_EN only).
//  stat_mispreds out  32  mispredicts seen (GSHARE_STATS_EN only).
// BEHAVIOUR
//  Reset (async): all counters = 2^(N-1)-1 (weakly not-taken); GHR=0; stats=0.
//   Outputs during reset: pred_ghr=0, pred_taken=0.
//  Predict: latency 0. pred_taken=pht[hash(pred_pc,GHR)][N-1]; pred_ghr=GHR. Valid regardless
//   of pred_valid; pred_valid only gates GHR advance and stats.
//  Speculative history: pred_valid & ~(upd_valid&upd_mispred) -> GHR <= {GHR[M-2:0],pred_taken}.
//  Recovery: upd_valid&upd_mispred -> GHR <= {upd_ghr[M-2:0],upd_taken}; overrides any same-
//   cycle predict shift (that prediction is on the wrong path and is squashed by fetch).
//  Update: upd_valid -> counter at hash(upd_pc,upd_ghr) saturating +1 if upd_taken else -1;
//   clamps at 2^N-1 and 0; written at next clk edge.
//  Read/write same entry same cycle: prediction returns pre-update value (no bypass).
//  upd_valid=0: table and GHR (except predict shift) unchanged; upd_mispred ignored.
//  M=1: shift degenerates to GHR<=new bit. Hash arithmetic wraps modulo 2^IW.
// CONFIGURATION
//  GSHARE_STATS_EN defined: stat_preds +1 per pred_valid cycle, stat_mispreds +1 per
//   upd_valid&upd_mispred cycle; both 32-bit, wrap 2^32-1 -> 0.
//  Not defined: no counters synthesised; stat_* tied to 0.
// STRUCTURE
//  gshare_pkg: localparam-style functions pht_index(pc,ghr) per HASH_XOR, sat_step(ctr,taken,N),
//   counter reset constant function weak_nt(N).
//  Sub-module ghr_unit: GHR register with speculative shift, mispredict restore and priority.
//  Top holds PHT array, index hashing, update write, optional stats.
// TESTING
//  Reset then predict any pc -> pred_taken=0, pred_ghr=0; all 2^IW entries read 2^(N-1)-1.
//  N=2, pc=3, 3 updates taken with upd_ghr=0 -> counter 0b11, 4th taken stays 0b11; 4 not-taken -> 0b00.
//  Three pred_valid predicting taken from GHR=0 -> GHR=0b0111; then upd_mispred, upd_ghr=0b0001,
//   upd_taken=0 -> GHR=0b0010 next cycle.
//  Same cycle pred_valid and upd_mispred -> GHR takes recovery value, predict shift dropped.
//  HASH_XOR=1, pc=0b1010, GHR=0b1010 -> entry 0 read; HASH_XOR=0 -> entry 0xAA read.
//  Assert reset mid-stream after training -> counters/GHR back to reset values immediately;
//   with GSHARE_STATS_EN, 5 preds + 2 mispreds -> stat_preds=5, stat_mispreds=2.

Source files
------------

// File: rtl/gshare_spec_predictor_pkg.sv
// Shared helpers for the gshare predictor: table index hashing, saturating counter step and the
// counter reset value.
package gshare_spec_predictor_pkg;

  // hash_xor=0 concatenates {ghr,pc}; hash_xor=1 folds ghr into the low pc bits (wraps mod 2^k).
  function automatic int unsigned pht_index(input int unsigned pc, input int unsigned ghr,
                                            input int unsigned k, input bit hash_xor);
    int unsigned k_mask;
    k_mask = (32'd1 << k) - 32'd1;
    if (hash_xor) begin
      return (pc ^ ghr) & k_mask;
    end
    return (ghr << k) | (pc & k_mask);
  endfunction

  function automatic int unsigned sat_step(input int unsigned ctr, input bit taken,
                                           input int unsigned n);
    int unsigned max_val;
    max_val = (32'd1 << n) - 32'd1;
    if (taken) begin
      return (ctr == max_val) ? ctr : ctr + 32'd1;
    end
    return (ctr == 32'd0) ? ctr : ctr - 32'd1;
  endfunction

  function automatic int unsigned weak_nt(input int unsigned n);
    return (32'd1 << (n - 32'd1)) - 32'd1;
  endfunction

endpackage

// File: rtl/gshare_spec_predictor_ghr_unit.sv
// Global history register: speculative shift on predict, restore from the resolved snapshot on
// mispredict. Restore wins over a same-cycle shift because that prediction is on the wrong path.
module gshare_spec_predictor_ghr_unit
  import gshare_spec_predictor_pkg::*;
#(
  parameter int unsigned M = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         spec_valid_i,
  input  logic         spec_bit_i,
  input  logic         restore_valid_i,
  input  logic [M-1:0] restore_ghr_i,
  input  logic         restore_bit_i,
  output logic [M-1:0] ghr_o
);

  logic [M-1:0] ghr_q, ghr_d;

  // Truncating the M+1-bit concatenation keeps {old[M-2:0], new_bit}; for M=1 just new_bit.
  always_comb begin
    ghr_d = ghr_q;
    if (restore_valid_i) begin
      ghr_d = M'({restore_ghr_i, restore_bit_i});
    end else if (spec_valid_i) begin
      ghr_d = M'({ghr_q, spec_bit_i});
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ghr_q <= '0;
    end else begin
      ghr_q <= ghr_d;
    end
  end

  assign ghr_o = ghr_q;

endmodule

// File: rtl/gshare_spec_predictor.sv
// Gshare branch direction predictor with speculative global history and mispredict recovery.
// Optional statistics counters are built when GSHARE_STATS_EN is defined.
module gshare_spec_predictor
  import gshare_spec_predictor_pkg::*;
#(
  parameter int unsigned K        = 4,
  parameter int unsigned M        = 4,
  parameter int unsigned N        = 2,
  parameter int unsigned HASH_XOR = 0
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pred_valid,
  input  logic [K-1:0] pred_pc,
  output logic         pred_taken,
  output logic [M-1:0] pred_ghr,
  input  logic         upd_valid,
  input  logic [K-1:0] upd_pc,
  input  logic [M-1:0] upd_ghr,
  input  logic         upd_taken,
  input  logic         upd_mispred,
  output logic [31:0]  stat_preds,
  output logic [31:0]  stat_mispreds
);

  localparam bit            HashXor = (HASH_XOR != 0);
  localparam int unsigned   IW      = HashXor ? K : K + M;
  localparam int unsigned   Depth   = 1 << IW;
  localparam logic [N-1:0]  WeakNt  = N'(weak_nt(N));

  logic [M-1:0]  ghr;
  logic [IW-1:0] pred_idx, upd_idx;
  logic [N-1:0]  pht_q [Depth];
  logic [N-1:0]  pht_d [Depth];
  logic          restore;

  assign restore  = upd_valid & upd_mispred;
  assign pred_idx = IW'(pht_index(32'(pred_pc), 32'(ghr), K, HashXor));
  assign upd_idx  = IW'(pht_index(32'(upd_pc), 32'(upd_ghr), K, HashXor));

  // Reads the registered table, so a same-entry update this cycle is not visible yet.
  assign pred_taken = pht_q[pred_idx][N-1];
  assign pred_ghr   = ghr;

  gshare_spec_predictor_ghr_unit #(
    .M (M)
  ) u_ghr (
    .clk             (clk),
    .reset           (reset),
    .spec_valid_i    (pred_valid),
    .spec_bit_i      (pred_taken),
    .restore_valid_i (restore),
    .restore_ghr_i   (upd_ghr),
    .restore_bit_i   (upd_taken),
    .ghr_o           (ghr)
  );

  always_comb begin
    pht_d = pht_q;
    if (upd_valid) begin
      pht_d[upd_idx] = N'(sat_step(32'(pht_q[upd_idx]), upd_taken, N));
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int unsigned i = 0; i < Depth; i++) begin
        pht_q[i] <= WeakNt;
      end
    end else begin
      pht_q <= pht_d;
    end
  end

`ifdef GSHARE_STATS_EN
  logic [31:0] stat_preds_q, stat_preds_d;
  logic [31:0] stat_mispreds_q, stat_mispreds_d;

  always_comb begin
    stat_preds_d    = stat_preds_q;
    stat_mispreds_d = stat_mispreds_q;
    if (pred_valid) begin
      stat_preds_d = stat_preds_q + 32'd1;
    end
    if (restore) begin
      stat_mispreds_d = stat_mispreds_q + 32'd1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      stat_preds_q    <= '0;
      stat_mispreds_q <= '0;
    end else begin
      stat_preds_q    <= stat_preds_d;
      stat_mispreds_q <= stat_mispreds_d;
    end
  end

  assign stat_preds    = stat_preds_q;
  assign stat_mispreds = stat_mispreds_q;
`else
  assign stat_preds    = '0;
  assign stat_mispreds = '0;
`endif

endmodule

// File: tb/tb_gshare_spec_predictor.sv
// Directed bench for gshare_spec_predictor: one concatenating-hash and one XOR-hash instance
// driven by the same stimulus.
module tb_gshare_spec_predictor;

  logic        clk = 1'b0;
  logic        reset;
  logic        pred_valid;
  logic [3:0]  pred_pc;
  logic        upd_valid;
  logic [3:0]  upd_pc;
  logic [3:0]  upd_ghr;
  logic        upd_taken;
  logic        upd_mispred;

  logic        taken0, taken1;
  logic [3:0]  ghr0, ghr1;
  logic [31:0] sp0, sm0, sp1, sm1;
  logic [31:0] exp_preds, exp_mispreds;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  gshare_spec_predictor #(.K(4), .M(4), .N(2), .HASH_XOR(0)) dut0 (
    .clk (clk), .reset (reset), .pred_valid (pred_valid), .pred_pc (pred_pc),
    .pred_taken (taken0), .pred_ghr (ghr0), .upd_valid (upd_valid), .upd_pc (upd_pc),
    .upd_ghr (upd_ghr), .upd_taken (upd_taken), .upd_mispred (upd_mispred),
    .stat_preds (sp0), .stat_mispreds (sm0)
  );

  gshare_spec_predictor #(.K(4), .M(4), .N(2), .HASH_XOR(1)) dut1 (
    .clk (clk), .reset (reset), .pred_valid (pred_valid), .pred_pc (pred_pc),
    .pred_taken (taken1), .pred_ghr (ghr1), .upd_valid (upd_valid), .upd_pc (upd_pc),
    .upd_ghr (upd_ghr), .upd_taken (upd_taken), .upd_mispred (upd_mispred),
    .stat_preds (sp1), .stat_mispreds (sm1)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset = 1'b1;
    pred_valid = 0; pred_pc = 0; upd_valid = 0; upd_pc = 0; upd_ghr = 0;
    upd_taken = 0; upd_mispred = 0;
    tick();
    chk("rst_taken0", 32'(taken0), 0);
    chk("rst_ghr0", 32'(ghr0), 0);
    chk("rst_taken1", 32'(taken1), 0);
    chk("rst_ghr1", 32'(ghr1), 0);
    tick();
    reset = 1'b0;
    for (int i = 0; i < 256; i++) chk("rst_pht0", 32'(dut0.pht_q[i]), 1);
    for (int i = 0; i < 16; i++) chk("rst_pht1", 32'(dut1.pht_q[i]), 1);
    chk("rst_stat_p", sp0, 0);
    chk("rst_stat_m", sm0, 0);

    // Saturation up then down at pc=3, ghr=0
    upd_valid = 1; upd_pc = 3; upd_ghr = 0; upd_taken = 1;
    tick(); chk("sat_up1", 32'(dut0.pht_q[3]), 2);
    tick(); chk("sat_up2", 32'(dut0.pht_q[3]), 3);
    tick(); chk("sat_up3", 32'(dut0.pht_q[3]), 3);
    tick(); chk("sat_up4", 32'(dut0.pht_q[3]), 3);
    pred_pc = 3;
    #1; chk("pred_sat", 32'(taken0), 1);
    upd_taken = 0;
    tick(); chk("sat_dn1", 32'(dut0.pht_q[3]), 2);
    chk("no_bypass", 32'(taken0), 1);
    tick(); chk("sat_dn2", 32'(dut0.pht_q[3]), 1);
    chk("pred_after", 32'(taken0), 0);
    tick(); chk("sat_dn3", 32'(dut0.pht_q[3]), 0);
    tick(); chk("sat_dn4", 32'(dut0.pht_q[3]), 0);
    chk("sat_dn4_x", 32'(dut1.pht_q[3]), 0);

    // Train pc=5 taken under ghr 0,1,3 so three speculative predictions go taken
    upd_pc = 5; upd_taken = 1; upd_ghr = 0;
    tick(); upd_ghr = 1;
    tick(); upd_ghr = 3;
    tick(); upd_valid = 0;
    chk("ghr_idle", 32'(ghr0), 0);
    pred_valid = 1; pred_pc = 5;
    #1; chk("spec_t0", 32'(taken0), 1);
    tick(); chk("spec_g1", 32'(ghr0), 1); chk("spec_t1", 32'(taken0), 1);
    chk("spec_g1_x", 32'(ghr1), 1); chk("spec_t1_x", 32'(taken1), 1);
    tick(); chk("spec_g3", 32'(ghr0), 3); chk("spec_t3", 32'(taken0), 1);
    tick(); pred_valid = 0;
    chk("spec_g7", 32'(ghr0), 7); chk("spec_g7_x", 32'(ghr1), 7);

    // Recovery
    upd_valid = 1; upd_mispred = 1; upd_ghr = 4'b0001; upd_taken = 0; upd_pc = 0;
    tick();
    chk("recover", 32'(ghr0), 2); chk("recover_x", 32'(ghr1), 2);
    chk("recover_pht", 32'(dut0.pht_q[8'h10]), 0);

    // Recovery beats same-cycle speculative shift
    pred_valid = 1; pred_pc = 5; upd_ghr = 4'b0011; upd_taken = 1;
    tick();
    chk("prio", 32'(ghr0), 7); chk("prio_x", 32'(ghr1), 7);

    // upd_mispred without upd_valid is ignored
    pred_valid = 0; upd_valid = 0; upd_mispred = 1; upd_ghr = 0;
    tick();
    chk("mis_novalid", 32'(ghr0), 7); chk("mis_novalid_x", 32'(ghr1), 7);

    // Asynchronous reset mid-cycle
    upd_mispred = 0; pred_pc = 5;
    #2; reset = 1'b1;
    #1;
    chk("mid_ghr", 32'(ghr0), 0);
    chk("mid_pht", 32'(dut0.pht_q[5]), 1);
    chk("mid_pht_x", 32'(dut1.pht_q[6]), 1);
    chk("mid_taken", 32'(taken0), 0);
    chk("mid_stat", sp0, 0);
    tick();
    reset = 1'b0;

    // Hash check: pc=0xA with ghr=0xA hits 0xAA (concat) and 0 (xor)
    upd_valid = 1; upd_pc = 4'hA; upd_ghr = 4'hA; upd_taken = 1;
    tick();
    chk("hash_pht0", 32'(dut0.pht_q[8'hAA]), 2);
    chk("hash_pht1", 32'(dut1.pht_q[0]), 2);
    upd_mispred = 1; upd_pc = 0; upd_ghr = 4'b0101; upd_taken = 0;
    tick(); upd_valid = 0; upd_mispred = 0;
    chk("hash_ghr0", 32'(ghr0), 4'hA); chk("hash_ghr1", 32'(ghr1), 4'hA);
    pred_pc = 4'hA; #1;
    chk("hash_hit0", 32'(taken0), 1); chk("hash_hit1", 32'(taken1), 1);
    pred_pc = 4'hB; #1;
    chk("hash_miss0", 32'(taken0), 0); chk("hash_miss1", 32'(taken1), 0);
    pred_pc = 4'h0; #1;
    chk("hash_pc0_x", 32'(taken1), 0);

    // Statistics: 5 predictions, 2 mispredicts since reset (one above, one here)
    pred_valid = 1;
    repeat (5) tick();
    pred_valid = 0; upd_valid = 1; upd_mispred = 1; upd_ghr = 0;
    tick();
    upd_valid = 0; upd_mispred = 0;
`ifdef GSHARE_STATS_EN
    exp_preds = 32'd5; exp_mispreds = 32'd2;
`else
    exp_preds = 32'd0; exp_mispreds = 32'd0;
`endif
    chk("stat_preds0", sp0, exp_preds); chk("stat_mis0", sm0, exp_mispreds);
    chk("stat_preds1", sp1, exp_preds); chk("stat_mis1", sm1, exp_mispreds);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
